// File: rtl/qtr4_emu.sv
// Quad QTR-RC sensor emulator: answers the host's charge pulse on each pin by
// holding the line high for a per-channel discharge time, counted in 10 us ticks.
module qtr4_ch (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       qs,
    input  logic       u10clk,
    input  logic [7:0] disc,
    output logic       arm,
    output logic       drv
);
    typedef enum logic [1:0] {IDLE, CHARGED, DISCH} state_t;
    state_t     state;
    logic [7:0] cnt;

    assign arm = (state == IDLE) && en && qs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
            drv   <= 1'b0;
        end else if (!en) begin
            state <= IDLE;
            drv   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (qs) state <= CHARGED;
                CHARGED: if (!qs) begin
                    cnt <= 8'd0;
                    if (disc == 8'd0) state <= IDLE;
                    else begin
                        state <= DISCH;
                        drv   <= 1'b1;
                    end
                end
                // pin level is ignored here; only the tick count ends the drive
                DISCH: if (u10clk) begin
                    if ({1'b0, cnt} + 9'd1 >= {1'b0, disc}) begin
                        state <= IDLE;
                        drv   <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    drv   <= 1'b0;
                end
            endcase
        end
    end
endmodule

module qtr4_emu #(
    parameter int NCH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdwr,
    input  logic        strobe,
    input  logic [3:0]  our_addr,
    input  logic [11:0] addr,
    input  logic        busy_in,
    output logic        busy_out,
    input  logic        addr_match_in,
    output logic        addr_match_out,
    input  logic [7:0]  datin,
    output logic [7:0]  datout,
    input  logic        u10clk,
    input  logic [3:0]  q_in,
    output logic [3:0]  q_out,
    output logic [3:0]  q_oe
);
    logic                myaddr;
    logic [NCH-1:0][7:0] disc;
    logic [NCH-1:0]      enable;
    logic [7:0]          evcount;
    logic [NCH-1:0]      q_s1, qs, arm, drv;
    logic [7:0]          rdata;

    assign myaddr         = (addr[11:8] == our_addr) && (addr[7:3] == 5'd0);
    assign busy_out       = busy_in;
    assign addr_match_out = myaddr | addr_match_in;

    always_comb begin
        rdata = 8'h00;
        case (addr[2:0])
            3'd0, 3'd1, 3'd2, 3'd3: rdata = disc[addr[1:0]];
            3'd4:                   rdata = {4'h0, enable};
            3'd5:                   rdata = evcount;
            default:                rdata = 8'h00;
        endcase
    end

    assign datout = !myaddr ? datin : (strobe ? rdata : 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disc   <= '0;
            enable <= '0;
        end else if (strobe && myaddr && !rdwr) begin
            case (addr[2:0])
                3'd0, 3'd1, 3'd2, 3'd3: disc[addr[1:0]] <= datin;
                3'd4:                   enable <= datin[3:0];
                default: ;
            endcase
        end
    end

    // simultaneous arms on several channels are one event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) evcount <= 8'd0;
        else if (|arm) evcount <= evcount + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_s1 <= '0;
            qs   <= '0;
        end else begin
            q_s1 <= q_in;
            qs   <= q_s1;
        end
    end

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        qtr4_ch u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (enable[n]),
            .qs     (qs[n]),
            .u10clk (u10clk),
            .disc   (disc[n]),
            .arm    (arm[n]),
            .drv    (drv[n])
        );
    end

    assign q_out = drv;
    assign q_oe  = drv;
endmodule
